// File: rtl/regfile_sb.sv
// regfile_sb: general-purpose register file with a per-register busy scoreboard.
//
// Sits between decode and writeback. Decode reads operands through two
// combinational read ports and reserves destination registers; writeback
// writes results, which releases the reservation. Decode stalls on rdN_busy.
//
// Parameters
//   DATA_W    register width
//   ADDR_W    address width, depth = 2**ADDR_W
//   ZERO_REG  1: register 0 reads 0, ignores writes, is never busy
//   BYPASS    1: same-cycle write forwards data to matching read ports and
//                masks their busy indication
//
// Ports
//   clk_i        clock, all state updates on rising edge
//   rst_n_i      synchronous active-low reset (clears data and busy bits)
//   rd1_addr_i   read port 1 address
//   rd1_data_o   read port 1 data, combinational
//   rd1_busy_o   read port 1 register has an outstanding reservation
//   rd2_addr_i   read port 2 address
//   rd2_data_o   read port 2 data, combinational
//   rd2_busy_o   read port 2 register has an outstanding reservation
//   we_i         write enable
//   wr_addr_i    write address
//   wr_data_i    write data
//   rsv_en_i     reserve a destination register
//   rsv_addr_i   register to reserve
//   busy_vec_o   registered busy bits, bit n = register n (no bypass)
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [ADDR_W-1:0]    rd1_addr_i,
  output logic [DATA_W-1:0]    rd1_data_o,
  output logic                 rd1_busy_o,
  input  logic [ADDR_W-1:0]    rd2_addr_i,
  output logic [DATA_W-1:0]    rd2_data_o,
  output logic                 rd2_busy_o,
  input  logic                 we_i,
  input  logic [ADDR_W-1:0]    wr_addr_i,
  input  logic [DATA_W-1:0]    wr_data_i,
  input  logic                 rsv_en_i,
  input  logic [ADDR_W-1:0]    rsv_addr_i,
  output logic [2**ADDR_W-1:0] busy_vec_o
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic              wr_ok;
  logic              rsv_ok;

  assign wr_ok  = we_i     && !((ZERO_REG == 1) && (wr_addr_i  == '0));
  assign rsv_ok = rsv_en_i && !((ZERO_REG == 1) && (rsv_addr_i == '0));

  // Set is applied after clear so a new producer issued in the same cycle
  // as the old producer's writeback keeps the register busy.
  always_comb begin
    busy_nxt = busy;
    if (we_i)   busy_nxt[wr_addr_i]  = 1'b0;
    if (rsv_ok) busy_nxt[rsv_addr_i] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      if (wr_ok) regs[wr_addr_i] <= wr_data_i;
      busy <= busy_nxt;
    end
  end

  assign busy_vec_o = busy;

  // Zero-register override is applied last so it beats the bypass path.
  always_comb begin
    rd1_data_o = regs[rd1_addr_i];
    rd1_busy_o = busy[rd1_addr_i];
    if ((BYPASS == 1) && we_i && (wr_addr_i == rd1_addr_i)) begin
      rd1_data_o = wr_data_i;
      rd1_busy_o = 1'b0;
    end
    if ((ZERO_REG == 1) && (rd1_addr_i == '0)) begin
      rd1_data_o = '0;
      rd1_busy_o = 1'b0;
    end
  end

  always_comb begin
    rd2_data_o = regs[rd2_addr_i];
    rd2_busy_o = busy[rd2_addr_i];
    if ((BYPASS == 1) && we_i && (wr_addr_i == rd2_addr_i)) begin
      rd2_data_o = wr_data_i;
      rd2_busy_o = 1'b0;
    end
    if ((ZERO_REG == 1) && (rd2_addr_i == '0)) begin
      rd2_data_o = '0;
      rd2_busy_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rd1_addr, rd2_addr, wr_addr, rsv_addr;
  logic        we, rsv_en;
  logic [31:0] wr_data;

  logic [31:0] a_rd1_data, a_rd2_data, b_rd1_data, b_rd2_data;
  logic        a_rd1_busy, a_rd2_busy, b_rd1_busy, b_rd2_busy;
  logic [31:0] a_busy_vec, b_busy_vec;

  int checks   = 0;
  int failures = 0;

  // Reference state
  logic [31:0] mem [32];
  bit          bsy [32];

  always #5 clk = ~clk;

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n),
    .rd1_addr_i(rd1_addr), .rd1_data_o(a_rd1_data), .rd1_busy_o(a_rd1_busy),
    .rd2_addr_i(rd2_addr), .rd2_data_o(a_rd2_data), .rd2_busy_o(a_rd2_busy),
    .we_i(we), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rsv_en_i(rsv_en), .rsv_addr_i(rsv_addr), .busy_vec_o(a_busy_vec));

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n),
    .rd1_addr_i(rd1_addr), .rd1_data_o(b_rd1_data), .rd1_busy_o(b_rd1_busy),
    .rd2_addr_i(rd2_addr), .rd2_data_o(b_rd2_data), .rd2_busy_o(b_rd2_busy),
    .we_i(we), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rsv_en_i(rsv_en), .rsv_addr_i(rsv_addr), .busy_vec_o(b_busy_vec));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(input logic [4:0] a, input bit byp);
    if (a == 0) return 32'h0;
    if (byp && we && wr_addr == a) return wr_data;
    return mem[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a, input bit byp);
    if (a == 0) return 1'b0;
    if (byp && we && wr_addr == a) return 1'b0;
    return bsy[a];
  endfunction

  function automatic logic [31:0] exp_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = bsy[i];
    return v;
  endfunction

  // One rising edge; the reference state follows the architectural rules.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        mem[i] = 32'h0;
        bsy[i] = 1'b0;
      end
    end else begin
      if (we && wr_addr != 0) mem[wr_addr] = wr_data;
      if (we) bsy[wr_addr] = 1'b0;
      if (rsv_en && rsv_addr != 0) bsy[rsv_addr] = 1'b1;
    end
    #1;
  endtask

  task automatic check_all(input string tag);
    #2;
    chk({tag, ":a_rd1_data"}, a_rd1_data, exp_data(rd1_addr, 1));
    chk({tag, ":a_rd1_busy"}, a_rd1_busy, exp_busy(rd1_addr, 1));
    chk({tag, ":a_rd2_data"}, a_rd2_data, exp_data(rd2_addr, 1));
    chk({tag, ":a_rd2_busy"}, a_rd2_busy, exp_busy(rd2_addr, 1));
    chk({tag, ":a_busy_vec"}, a_busy_vec, exp_vec());
    chk({tag, ":b_rd1_data"}, b_rd1_data, exp_data(rd1_addr, 0));
    chk({tag, ":b_rd1_busy"}, b_rd1_busy, exp_busy(rd1_addr, 0));
    chk({tag, ":b_rd2_data"}, b_rd2_data, exp_data(rd2_addr, 0));
    chk({tag, ":b_rd2_busy"}, b_rd2_busy, exp_busy(rd2_addr, 0));
    chk({tag, ":b_busy_vec"}, b_busy_vec, exp_vec());
  endtask

  task automatic idle();
    we = 0; rsv_en = 0; wr_addr = 0; wr_data = 0; rsv_addr = 0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[i] = 32'h0;
      bsy[i] = 1'b0;
    end
    rst_n = 0; rd1_addr = 0; rd2_addr = 0;
    idle();

    // Reset overrides a write
    we = 1; wr_addr = 3; wr_data = 32'hFFFF_FFFF;
    tick(); tick();
    rst_n = 1; idle(); rd1_addr = 3;
    check_all("reset");
    chk("reset_rd1_r3", a_rd1_data, 32'h0);
    chk("reset_vec", a_busy_vec, 32'h0);

    // Write / read / zero register
    we = 1; wr_addr = 5; wr_data = 32'h1234_5678; tick();
    wr_addr = 0; wr_data = 32'hDEAD_BEEF; tick();
    idle(); rd1_addr = 5; rd2_addr = 0;
    check_all("wr_rd");
    chk("wr_rd_r5", a_rd1_data, 32'h1234_5678);
    chk("wr_rd_r0", a_rd2_data, 32'h0);

    // Bypass vs. no bypass
    we = 1; wr_addr = 7; wr_data = 32'h11; tick();
    wr_data = 32'h22; rd1_addr = 7;
    check_all("byp_cycle");
    chk("byp_a_same_cycle", a_rd1_data, 32'h22);
    chk("byp_b_same_cycle", b_rd1_data, 32'h11);
    tick(); idle();
    check_all("byp_after");
    chk("byp_b_after", b_rd1_data, 32'h22);

    // Scoreboard lifecycle
    rsv_en = 1; rsv_addr = 9; rd2_addr = 9;
    check_all("rsv_same_cycle");
    chk("rsv_not_yet", a_rd2_busy, 1'b0);
    tick(); idle();
    check_all("rsv_after");
    chk("rsv_busy", a_rd2_busy, 1'b1);
    chk("rsv_vec9", a_busy_vec[9], 1'b1);
    we = 1; wr_addr = 9; wr_data = 32'h5;
    check_all("wb_cycle");
    chk("wb_a_busy_masked", a_rd2_busy, 1'b0);
    chk("wb_b_busy_held", b_rd2_busy, 1'b1);
    tick(); idle();
    check_all("wb_after");
    chk("wb_vec9", a_busy_vec[9], 1'b0);

    // Set/clear collision, reserve r0
    rsv_en = 1; rsv_addr = 4; we = 1; wr_addr = 4; wr_data = 32'hABCD; rd1_addr = 4;
    tick(); idle();
    check_all("collide");
    chk("collide_vec4", a_busy_vec[4], 1'b1);
    chk("collide_data", a_rd1_data, 32'hABCD);
    rsv_en = 1; rsv_addr = 0; tick(); idle();
    check_all("rsv_r0");
    chk("rsv_r0_vec0", a_busy_vec[0], 1'b0);

    // Reset mid-operation
    we = 1; wr_addr = 1; wr_data = 32'h77; tick();
    idle();
    for (int r = 1; r <= 3; r++) begin
      rsv_en = 1; rsv_addr = 5'(r); tick();
    end
    idle(); rd1_addr = 1; rd2_addr = 2;
    check_all("pre_rst");
    chk("pre_rst_r1", a_rd1_data, 32'h77);
    rst_n = 0; tick(); rst_n = 1;
    check_all("mid_rst");
    chk("mid_rst_vec", a_busy_vec, 32'h0);
    chk("mid_rst_r1", a_rd1_data, 32'h0);
    rd1_addr = 3;
    check_all("mid_rst_r3");

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      rst_n    = ($urandom_range(0, 59) != 0);
      we       = $urandom_range(0, 1);
      rsv_en   = $urandom_range(0, 1);
      wr_addr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      rsv_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      wr_data  = $urandom;
      rd1_addr = ($urandom_range(0, 2) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      rd2_addr = ($urandom_range(0, 3) == 0) ? rd1_addr : 5'($urandom_range(0, 31));
      check_all("rand");
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
